// File: rtl/hoplite_client.sv
// hoplite_client: client-side adapter between N_CH injection channels and a
// Hoplite torus router port.
//   - Injection: one FIFO per channel; packets are formed as
//     {dst_x, dst_y, ch, payload}. A round-robin arbiter picks the head that
//     is offered to the router, rate-limited by a token bucket that refills
//     one token every MAX_RATE cycles, up to MAX_TOKEN tokens.
//   - Ejection: router packets are registered (1-cycle latency) and split into
//     payload and channel ID. Packets addressed to a channel >= N_CH are dropped.
//   - Statistics: inj_cnt_o, ej_cnt_o and drop_cnt_o count accepts, ejections
//     and drops. They exist only when HOPLITE_CLIENT_STATS_EN is defined;
//     otherwise they read as 0.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   inj_data_i/dst_x/dst_y    per-channel payload and destination, channel c at slice c
//   inj_valid_i/inj_ready_o   per-channel injection handshake
//   noc_out_pkt_o/vld_o       packet offered to the router, accepted with noc_rdy_i
//   noc_in_pkt_i/vld_i        packet ejected by the router
//   ej_data_o/ch_o/valid_o    registered ejection output
//   inj_cnt_o/ej_cnt_o/drop_cnt_o  32-bit wrapping statistics counters
module hoplite_client #(
  parameter int P_W        = 32,
  parameter int X_DIM      = 2,
  parameter int Y_DIM      = 2,
  parameter int N_CH       = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_RATE   = 4,
  parameter int MAX_TOKEN  = 2,
  localparam int XW  = (X_DIM == 1) ? 1 : $clog2(X_DIM),
  localparam int YW  = (Y_DIM == 1) ? 1 : $clog2(Y_DIM),
  localparam int CW  = (N_CH == 1) ? 1 : $clog2(N_CH),
  localparam int D_W = P_W - XW - YW - CW
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_CH*D_W-1:0]   inj_data_i,
  input  logic [N_CH*XW-1:0]    inj_dst_x_i,
  input  logic [N_CH*YW-1:0]    inj_dst_y_i,
  input  logic [N_CH-1:0]       inj_valid_i,
  output logic [N_CH-1:0]       inj_ready_o,
  output logic [P_W-1:0]        noc_out_pkt_o,
  output logic                  noc_out_vld_o,
  input  logic                  noc_rdy_i,
  input  logic [P_W-1:0]        noc_in_pkt_i,
  input  logic                  noc_in_vld_i,
  output logic [D_W-1:0]        ej_data_o,
  output logic [CW-1:0]         ej_ch_o,
  output logic                  ej_valid_o,
  output logic [31:0]           inj_cnt_o,
  output logic [31:0]           ej_cnt_o,
  output logic [31:0]           drop_cnt_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(MAX_TOKEN + 1);
  localparam int RW = (MAX_RATE <= 1) ? 1 : $clog2(MAX_RATE);

  logic [P_W-1:0] mem_q    [N_CH][FIFO_DEPTH];
  logic [P_W-1:0] mem_d    [N_CH][FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr_q [N_CH];
  logic [AW-1:0]  wr_ptr_d [N_CH];
  logic [AW-1:0]  rd_ptr_q [N_CH];
  logic [AW-1:0]  rd_ptr_d [N_CH];
  logic [AW:0]    cnt_q    [N_CH];
  logic [AW:0]    cnt_d    [N_CH];

  logic [N_CH-1:0] empty, full, push, pop;
  logic [CW-1:0]   rr_ptr_q, rr_ptr_d, sel, lock_ch_q, lock_ch_d;
  logic            lock_q, lock_d, any_ne, accept, refill;
  logic [TW-1:0]   tokens_q, tokens_d;
  logic [RW-1:0]   rate_q, rate_d;

  logic            ej_valid_q, ej_valid_d;
  logic [D_W-1:0]  ej_data_q, ej_data_d;
  logic [CW-1:0]   ej_ch_q, ej_ch_d;
  logic [CW-1:0]   in_ch;
  logic            in_ch_ok;
  logic            unused_in_dst;

  // FIFO status and push handshake; ready is forced low while in reset.
  always_comb begin
    empty       = '0;
    full        = '0;
    inj_ready_o = '0;
    push        = '0;
    for (int unsigned c = 0; c < N_CH; c++) begin
      empty[c]       = (cnt_q[c] == '0);
      full[c]        = (cnt_q[c] == (AW+1)'(FIFO_DEPTH));
      inj_ready_o[c] = !full[c] && !rst;
      push[c]        = inj_valid_i[c] && inj_ready_o[c];
    end
  end

  // Round-robin pick of the first non-empty channel from rr_ptr. A packet
  // that was offered but refused stays selected until accepted, so a push
  // into a higher-priority channel cannot change the offered packet.
  always_comb begin
    int unsigned idx;
    logic [CW-1:0] cand;
    sel    = rr_ptr_q;
    any_ne = 1'b0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      idx = 32'(rr_ptr_q) + i;
      if (idx >= N_CH) idx = idx - N_CH;
      cand = CW'(idx);
      if (!any_ne && !empty[cand]) begin
        any_ne = 1'b1;
        sel    = cand;
      end
    end
    if (lock_q) begin
      any_ne = 1'b1;
      sel    = lock_ch_q;
    end
  end

  assign noc_out_vld_o = any_ne && (tokens_q != '0) && !rst;
  assign noc_out_pkt_o = mem_q[sel][rd_ptr_q[sel]];
  assign accept        = noc_out_vld_o && noc_rdy_i;

  // FIFO next state.
  always_comb begin
    mem_d = mem_q;
    pop   = '0;
    for (int unsigned c = 0; c < N_CH; c++) begin
      pop[c]      = accept && (sel == CW'(c));
      wr_ptr_d[c] = wr_ptr_q[c] + AW'(push[c]);
      rd_ptr_d[c] = rd_ptr_q[c] + AW'(pop[c]);
      cnt_d[c]    = cnt_q[c] + (AW+1)'(push[c]) - (AW+1)'(pop[c]);
      if (push[c]) begin
        mem_d[c][wr_ptr_q[c]] = {inj_dst_x_i[c*XW +: XW], inj_dst_y_i[c*YW +: YW],
                                 CW'(c), inj_data_i[c*D_W +: D_W]};
      end
    end
  end

  // Token bucket, arbiter pointer and offer lock.
  always_comb begin
    refill   = (rate_q == RW'(MAX_RATE - 1));
    rate_d   = refill ? '0 : rate_q + RW'(1);
    tokens_d = tokens_q;
    if (refill && !accept) begin
      if (tokens_q != TW'(MAX_TOKEN)) tokens_d = tokens_q + TW'(1);
    end else if (!refill && accept) begin
      tokens_d = tokens_q - TW'(1);
    end
    rr_ptr_d = rr_ptr_q;
    if (accept) rr_ptr_d = (sel == CW'(N_CH - 1)) ? '0 : sel + CW'(1);
    lock_d    = noc_out_vld_o && !noc_rdy_i;
    lock_ch_d = sel;
  end

  // Ejection path.
  assign in_ch         = noc_in_pkt_i[D_W +: CW];
  assign unused_in_dst = ^noc_in_pkt_i[P_W-1:D_W+CW];

  if ((2 ** CW) > N_CH) begin : g_ch_filter
    assign in_ch_ok = ({1'b0, in_ch} < (CW+1)'(N_CH));
  end else begin : g_ch_all_valid
    assign in_ch_ok = 1'b1;
  end

  always_comb begin
    ej_valid_d = noc_in_vld_i && in_ch_ok;
    ej_data_d  = ej_valid_d ? noc_in_pkt_i[D_W-1:0] : ej_data_q;
    ej_ch_d    = ej_valid_d ? in_ch : ej_ch_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned c = 0; c < N_CH; c++) begin
        wr_ptr_q[c] <= '0;
        rd_ptr_q[c] <= '0;
        cnt_q[c]    <= '0;
      end
      rr_ptr_q   <= '0;
      lock_q     <= 1'b0;
      lock_ch_q  <= '0;
      tokens_q   <= TW'(MAX_TOKEN);
      rate_q     <= '0;
      ej_valid_q <= 1'b0;
      ej_data_q  <= '0;
      ej_ch_q    <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      rr_ptr_q   <= rr_ptr_d;
      lock_q     <= lock_d;
      lock_ch_q  <= lock_ch_d;
      tokens_q   <= tokens_d;
      rate_q     <= rate_d;
      ej_valid_q <= ej_valid_d;
      ej_data_q  <= ej_data_d;
      ej_ch_q    <= ej_ch_d;
    end
  end

  // Storage has no reset; occupancy is tracked by the pointers and counts.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign ej_valid_o = ej_valid_q;
  assign ej_data_o  = ej_data_q;
  assign ej_ch_o    = ej_ch_q;

`ifdef HOPLITE_CLIENT_STATS_EN
  logic [31:0] inj_cnt_q, inj_cnt_d, ej_cnt_q, ej_cnt_d, drop_cnt_q, drop_cnt_d;

  always_comb begin
    inj_cnt_d  = inj_cnt_q + 32'(accept);
    ej_cnt_d   = ej_cnt_q + 32'(ej_valid_d);
    drop_cnt_d = drop_cnt_q + 32'(noc_in_vld_i && !in_ch_ok);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inj_cnt_q  <= '0;
      ej_cnt_q   <= '0;
      drop_cnt_q <= '0;
    end else begin
      inj_cnt_q  <= inj_cnt_d;
      ej_cnt_q   <= ej_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign inj_cnt_o  = inj_cnt_q;
  assign ej_cnt_o   = ej_cnt_q;
  assign drop_cnt_o = drop_cnt_q;
`else
  assign inj_cnt_o  = '0;
  assign ej_cnt_o   = '0;
  assign drop_cnt_o = '0;
`endif

endmodule

// File: tb/tb_hoplite_client.sv
// Bench for hoplite_client. Instance A uses default parameters and is checked
// every cycle against a queue-based reference model; instance B (N_CH=3,
// MAX_RATE=1) covers round-robin order and invalid-channel drops.
module tb_hoplite_client;

`ifdef HOPLITE_CLIENT_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  // Instance A widths: X=Y=N_CH=2 -> XW=YW=CW=1, D_W=29.
  localparam int A_NCH = 2, A_DW = 29, A_DEPTH = 4, A_RATE = 4, A_TOK = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- instance A ----------------
  logic            rst_a = 1'b1;
  logic [57:0]     a_data = '0;
  logic [1:0]      a_dx = '0, a_dy = '0, a_v = '0;
  logic [1:0]      a_rdy_o;
  logic [31:0]     a_pkt_o;
  logic            a_vld_o;
  logic            a_nrdy = 1'b0;
  logic [31:0]     a_in_pkt = '0;
  logic            a_in_vld = 1'b0;
  logic [28:0]     a_ej_data;
  logic [0:0]      a_ej_ch;
  logic            a_ej_v;
  logic [31:0]     a_inj_cnt, a_ej_cnt, a_drop_cnt;

  hoplite_client u_a (
    .clk(clk), .rst(rst_a),
    .inj_data_i(a_data), .inj_dst_x_i(a_dx), .inj_dst_y_i(a_dy),
    .inj_valid_i(a_v), .inj_ready_o(a_rdy_o),
    .noc_out_pkt_o(a_pkt_o), .noc_out_vld_o(a_vld_o), .noc_rdy_i(a_nrdy),
    .noc_in_pkt_i(a_in_pkt), .noc_in_vld_i(a_in_vld),
    .ej_data_o(a_ej_data), .ej_ch_o(a_ej_ch), .ej_valid_o(a_ej_v),
    .inj_cnt_o(a_inj_cnt), .ej_cnt_o(a_ej_cnt), .drop_cnt_o(a_drop_cnt)
  );

  // ---------------- instance B ----------------
  logic            rst_b = 1'b1;
  logic [83:0]     b_data = '0;
  logic [2:0]      b_dx = '0, b_dy = '0, b_v = '0;
  logic [2:0]      b_rdy_o;
  logic [31:0]     b_pkt_o;
  logic            b_vld_o;
  logic            b_nrdy = 1'b0;
  logic [31:0]     b_in_pkt = '0;
  logic            b_in_vld = 1'b0;
  logic [27:0]     b_ej_data;
  logic [1:0]      b_ej_ch;
  logic            b_ej_v;
  logic [31:0]     b_inj_cnt, b_ej_cnt, b_drop_cnt;

  hoplite_client #(.N_CH(3), .MAX_RATE(1)) u_b (
    .clk(clk), .rst(rst_b),
    .inj_data_i(b_data), .inj_dst_x_i(b_dx), .inj_dst_y_i(b_dy),
    .inj_valid_i(b_v), .inj_ready_o(b_rdy_o),
    .noc_out_pkt_o(b_pkt_o), .noc_out_vld_o(b_vld_o), .noc_rdy_i(b_nrdy),
    .noc_in_pkt_i(b_in_pkt), .noc_in_vld_i(b_in_vld),
    .ej_data_o(b_ej_data), .ej_ch_o(b_ej_ch), .ej_valid_o(b_ej_v),
    .inj_cnt_o(b_inj_cnt), .ej_cnt_o(b_ej_cnt), .drop_cnt_o(b_drop_cnt)
  );

  // ---------------- reference model for A ----------------
  logic [31:0] mq [A_NCH][$];
  int          m_tok = A_TOK, m_rc = 0, m_rr = 0, m_held = -1;
  bit          m_known = 1'b0;
  bit          m_ejv = 1'b0;
  logic [28:0] m_ejd = '0;
  logic        m_ejc = 1'b0;
  logic [31:0] m_inj = '0, m_ej = '0, m_drop = '0;

  // One clock cycle on A: drive inputs after the falling edge, compare DUT
  // outputs with the model, then advance the model across the rising edge.
  // dacc reports what the DUT itself did (offered and router ready).
  task automatic step_a(input bit r, input logic [1:0] v, input logic [57:0] d,
                        input logic [1:0] dx, input logic [1:0] dy, input bit nrdy,
                        input logic [31:0] ip, input bit iv, output bit dacc);
    logic [1:0] e_rdy;
    int         sel, c;
    bit         e_vld, acc, refill;
    @(negedge clk);
    rst_a = r; a_v = v; a_data = d; a_dx = dx; a_dy = dy;
    a_nrdy = nrdy; a_in_pkt = ip; a_in_vld = iv;
    #1;
    for (int i = 0; i < A_NCH; i++) e_rdy[i] = !r && (mq[i].size() < A_DEPTH);
    sel = -1;
    if (m_held >= 0) sel = m_held;
    else for (int i = 0; i < A_NCH; i++) begin
      c = (m_rr + i) % A_NCH;
      if (sel < 0 && mq[c].size() != 0) sel = c;
    end
    e_vld = !r && (sel >= 0) && (m_tok > 0);
    chk("inj_ready", a_rdy_o, e_rdy);
    chk("out_vld", a_vld_o, e_vld);
    if (e_vld) chk("out_pkt", a_pkt_o, mq[sel][0]);
    if (m_known) begin
      chk("ej_valid", a_ej_v, m_ejv);
      if (m_ejv) begin
        chk("ej_data", a_ej_data, m_ejd);
        chk("ej_ch", a_ej_ch, m_ejc);
      end
      chk("inj_cnt", a_inj_cnt, STATS ? m_inj : 32'd0);
      chk("ej_cnt", a_ej_cnt, STATS ? m_ej : 32'd0);
      chk("drop_cnt", a_drop_cnt, STATS ? m_drop : 32'd0);
    end
    dacc = a_vld_o && nrdy;
    acc  = e_vld && nrdy;
    if (r) begin
      for (int i = 0; i < A_NCH; i++) mq[i].delete();
      m_tok = A_TOK; m_rc = 0; m_rr = 0; m_held = -1; m_ejv = 1'b0;
      m_ejd = '0; m_ejc = 1'b0; m_inj = '0; m_ej = '0; m_drop = '0;
      m_known = 1'b1;
    end else begin
      refill = (m_rc == A_RATE - 1);
      m_rc   = refill ? 0 : m_rc + 1;
      if (refill && !acc) m_tok = (m_tok < A_TOK) ? m_tok + 1 : A_TOK;
      else if (!refill && acc) m_tok = m_tok - 1;
      if (acc) begin
        void'(mq[sel].pop_front());
        m_rr = (sel + 1) % A_NCH;
        m_inj++;
      end
      m_held = (e_vld && !nrdy) ? sel : -1;
      for (int i = 0; i < A_NCH; i++)
        if (v[i] && e_rdy[i]) mq[i].push_back({dx[i], dy[i], 1'(i), d[i*A_DW +: A_DW]});
      if (iv && int'(ip[29]) < A_NCH) begin
        m_ejv = 1'b1; m_ejd = ip[28:0]; m_ejc = ip[29]; m_ej++;
      end else begin
        m_ejv = 1'b0;
        if (iv) m_drop++;
      end
    end
  endtask

  task automatic idle_a(input bit nrdy, output bit dacc);
    step_a(1'b0, 2'b00, '0, '0, '0, nrdy, '0, 1'b0, dacc);
  endtask

  task automatic tick_b(input bit r, input logic [2:0] v, input bit nrdy,
                        input logic [31:0] ip, input bit iv);
    @(negedge clk);
    rst_b = r; b_v = v; b_nrdy = nrdy; b_in_pkt = ip; b_in_vld = iv;
    b_data = 84'({$urandom, $urandom, $urandom});
    b_dx = 3'($urandom); b_dy = 3'($urandom);
    #1;
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    bit          dacc;
    logic [11:0] pat;
    logic [57:0] d;
    logic [31:0] first_pkt;
    logic [31:0] base;
    logic [1:0]  got_ch [$];

    // Reset and reset-state checks.
    step_a(1'b1, 2'b11, '0, '0, '0, 1'b1, '0, 1'b0, dacc);
    step_a(1'b1, 2'b11, '0, '0, '0, 1'b1, '0, 1'b0, dacc);
    chk("rst_ej_valid", a_ej_v, 1'b0);
    chk("rst_ej_data", a_ej_data, '0);
    chk("rst_ej_ch", a_ej_ch, '0);
    chk("rst_inj_cnt", a_inj_cnt, '0);

    // Token burst: 4 pushes on ch0, router always ready.
    pat = '0;
    for (int i = 0; i < 12; i++) begin
      step_a(1'b0, (i < 4) ? 2'b01 : 2'b00, 58'({$urandom, $urandom}), 2'b01, 2'b00,
             1'b1, '0, 1'b0, dacc);
      pat[i] = dacc;
    end
    chk("burst_accepts", pat, 12'h116);

    // Full FIFO and backpressure on ch1.
    step_a(1'b1, 2'b00, '0, '0, '0, 1'b0, '0, 1'b0, dacc);
    for (int i = 0; i < 4; i++) begin
      d = 58'({$urandom, $urandom});
      if (i == 0) first_pkt = {1'b1, 1'b0, 1'b1, d[57:29]};
      step_a(1'b0, 2'b10, d, 2'b10, 2'b00, 1'b0, '0, 1'b0, dacc);
    end
    for (int i = 0; i < 3; i++) begin
      step_a(1'b0, 2'b10, 58'({$urandom, $urandom}), 2'b10, 2'b00, 1'b0, '0, 1'b0, dacc);
      chk("full_ready1", a_rdy_o[1], 1'b0);
      chk("stall_pkt", a_pkt_o, first_pkt);
    end
    for (int i = 0; i < 16; i++) idle_a(1'b1, dacc);

    // Ejection of {1,0,1,29'h5A}.
    step_a(1'b0, 2'b00, '0, '0, '0, 1'b1, {1'b1, 1'b0, 1'b1, 29'h5A}, 1'b1, dacc);
    idle_a(1'b1, dacc);
    chk("ej46_valid", a_ej_v, 1'b1);
    chk("ej46_ch", a_ej_ch, 1'b1);
    chk("ej46_data", a_ej_data, 29'h5A);

    // Mid-operation reset with 3 packets queued.
    step_a(1'b0, 2'b11, 58'({$urandom, $urandom}), 2'b11, 2'b01, 1'b0, '0, 1'b0, dacc);
    step_a(1'b0, 2'b01, 58'({$urandom, $urandom}), 2'b01, 2'b10, 1'b0, '0, 1'b0, dacc);
    step_a(1'b1, 2'b11, 58'({$urandom, $urandom}), 2'b00, 2'b00, 1'b1, '0, 1'b0, dacc);
    idle_a(1'b0, dacc);
    chk("midrst_ready", a_rdy_o, 2'b11);
    chk("midrst_vld", a_vld_o, 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      step_a($urandom_range(0, 63) == 0, 2'($urandom), 58'({$urandom, $urandom}),
             2'($urandom), 2'($urandom), $urandom_range(0, 9) < 7,
             $urandom, $urandom_range(0, 3) == 0, dacc);
    end

    // Instance B: round-robin with plentiful tokens.
    tick_b(1'b1, 3'b000, 1'b0, '0, 1'b0);
    tick_b(1'b1, 3'b000, 1'b0, '0, 1'b0);
    tick_b(1'b0, 3'b011, 1'b0, '0, 1'b0);
    tick_b(1'b0, 3'b011, 1'b0, '0, 1'b0);
    for (int i = 0; i < 20 && got_ch.size() < 4; i++) begin
      tick_b(1'b0, 3'b000, 1'b1, '0, 1'b0);
      if (b_vld_o) got_ch.push_back(b_pkt_o[29:28]);
    end
    chk("rr_count", 64'(got_ch.size()), 64'd4);
    for (int i = 0; i < got_ch.size(); i++) chk("rr_order", got_ch[i], 2'(i % 2));

    // Instance B: channel 3 is out of range and dropped; channel 2 is valid.
    base = b_drop_cnt;
    tick_b(1'b0, 3'b000, 1'b1, {2'b00, 2'd3, 28'h123}, 1'b1);
    tick_b(1'b0, 3'b000, 1'b1, '0, 1'b0);
    chk("drop_ej_valid", b_ej_v, 1'b0);
    chk("drop_cnt_b", b_drop_cnt, STATS ? base + 32'd1 : 32'd0);
    tick_b(1'b0, 3'b000, 1'b1, {2'b11, 2'd2, 28'hABC}, 1'b1);
    tick_b(1'b0, 3'b000, 1'b1, '0, 1'b0);
    chk("ch2_ej_valid", b_ej_v, 1'b1);
    chk("ch2_ej_ch", b_ej_ch, 2'd2);
    chk("ch2_ej_data", b_ej_data, 28'hABC);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
